// File: rtl/tx_symbol_sched.sv
// tx_symbol_sched: paces 4-ASK symbols into the TX shaping filter, zero-stuffed to SPS samples.
// Build option SYM_PRBS_EN adds prbs_sel_i and an internal x^7+x^6+1 symbol source.
module tx_symbol_sched #(
  parameter int unsigned      CLK_DIV   = 4,
  parameter int unsigned      SPS       = 4,
  parameter int unsigned      DRAIN_LEN = 21,
  parameter logic signed [17:0] LVL_A   = 18'sd16384
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [1:0]         sym_in_i,
  input  logic               sym_valid_i,
`ifdef SYM_PRBS_EN
  input  logic               prbs_sel_i,
`endif
  output logic               sym_ready_o,
  output logic signed [17:0] x_out_o,
  output logic               samp_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               underrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int DR_W  = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_LEN - 1);
  localparam logic signed [17:0] LVL_3A = 18'(3 * LVL_A);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [PH_W-1:0]   phase_q;
  logic [DR_W-1:0]   drain_cnt_q;
  logic              stop_pend_q;
  logic signed [17:0] x_q;
  logic              samp_en_q;
  logic              done_q;
  logic              underrun_q;

  logic              tick;
  logic              sym_tick;
  logic              use_prbs_d;
  logic [1:0]        prbs_sym_d;

  // Gray-coded 4-ASK: adjacent levels differ in one bit.
  function automatic logic signed [17:0] level(input logic [1:0] s);
    case (s)
      2'b00:   return -LVL_3A;
      2'b01:   return -LVL_A;
      2'b11:   return LVL_A;
      default: return LVL_3A;
    endcase
  endfunction

`ifdef SYM_PRBS_EN
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_s1_d;
  logic [6:0] lfsr_s2_d;

  assign lfsr_s1_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  assign lfsr_s2_d  = {lfsr_s1_d[5:0], lfsr_s1_d[6] ^ lfsr_s1_d[5]};
  assign prbs_sym_d = {lfsr_s1_d[0], lfsr_s2_d[0]};
  assign use_prbs_d = prbs_sel_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= 7'h7F;
    end else if (sym_tick && use_prbs_d) begin
      lfsr_q <= lfsr_s2_d;
    end
  end
`else
  assign prbs_sym_d = 2'b00;
  assign use_prbs_d = 1'b0;
`endif

  assign tick        = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
  assign sym_tick    = tick && (state_q == S_RUN) && (phase_q == '0);
  assign sym_ready_o = sym_tick && !use_prbs_d;

  assign x_out_o    = x_q;
  assign samp_en_o  = samp_en_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign underrun_o = underrun_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      drain_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      x_q         <= '0;
      samp_en_q   <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      samp_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_RUN;
            div_cnt_q   <= '0;
            phase_q     <= '0;
            stop_pend_q <= 1'b0;
            underrun_q  <= 1'b0;
          end
        end

        S_RUN: begin
          if (stop_i) stop_pend_q <= 1'b1;
          div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
          if (tick) begin
            samp_en_q <= 1'b1;
            if (phase_q == '0) begin
              if (use_prbs_d) begin
                x_q <= level(prbs_sym_d);
              end else if (sym_valid_i) begin
                x_q <= level(sym_in_i);
              end else begin
                x_q        <= '0;
                underrun_q <= 1'b1;
              end
            end else begin
              x_q <= '0;
            end
            if (phase_q == PH_LAST) begin
              phase_q <= '0;
              // Stop only takes effect once the current symbol has been fully emitted.
              if (stop_pend_q) begin
                state_q     <= S_DRAIN;
                drain_cnt_q <= '0;
                stop_pend_q <= 1'b0;
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
          if (tick) begin
            samp_en_q <= 1'b1;
            x_q       <= '0;
            if (drain_cnt_q == DR_LAST) begin
              state_q     <= S_IDLE;
              done_q      <= 1'b1;
              div_cnt_q   <= '0;
              drain_cnt_q <= '0;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_symbol_sched.md
Name: tx_symbol_sched

Overview:
Sample-rate scheduler in front of the TX pulse-shaping filter (TX_filt_MF).
- Pulls 2-bit symbols from an upstream source over a valid/ready handshake.
- Maps each symbol to a 4-ASK 1s17 level and zero-stuffs to SPS samples per symbol.
- Issues one sample strobe every CLK_DIV clocks.
- On stop, flushes the filter with DRAIN_LEN zero samples before returning idle.

Parameters:
CLK_DIV, 4, clocks per output sample (>=2)
SPS, 4, samples per symbol (>=2)
DRAIN_LEN, 21, zero samples emitted in DRAIN (>=1)
LVL_A, 18'sd16384, inner ASK amplitude a in 1s17; outer = 3a

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin transmission (sampled in IDLE only)
stop  in  1  request end of transmission (sampled in RUN only)
sym_in  in  2  symbol bits
sym_valid  in  1  sym_in valid
sym_ready  out  1  symbol accepted this cycle (combinational)
x_out  out  18  signed 1s17 sample to filter x_in
samp_en  out  1  one-cycle strobe; x_out holds the new sample this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE
underrun  out  1  sticky: symbol needed but sym_valid low

Behaviour:
- Reset (async, any state): state=IDLE, div_cnt=0, phase=0, drain_cnt=0, stop_pend=0; x_out=0, samp_en=0, busy=0, done=0, underrun=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> RUN next cycle, with div_cnt=0, phase=0, underrun cleared.
  - stop ignored, including when simultaneous with start.
  - samp_en=0; x_out holds 0.
- div_cnt counts 0..CLK_DIV-1 and wraps in RUN/DRAIN. tick = (div_cnt==CLK_DIV-1).
- On each tick edge: samp_en<=1 for exactly the following cycle and x_out is loaded. samp_en=0 on all other cycles.
- RUN, per tick:
  - phase==0:
    - sym_ready = tick & (phase==0) & (state==RUN), asserted combinationally.
    - If sym_valid: x_out <= level(sym_in).
    - Else: x_out <= 0 and underrun <= 1.
  - phase!=0: x_out <= 0.
  - phase increments and wraps SPS-1 -> 0.
- Level map (Gray): 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a. Computed in 18-bit signed, no saturation; 3*LVL_A must be <= 131071.
- stop in RUN sets stop_pend. On the tick with phase==SPS-1 and stop_pend=1: that sample is emitted normally, then the state moves to DRAIN with drain_cnt=0 and stop_pend=0. The current symbol is never truncated.
- DRAIN, per tick: x_out <= 0, drain_cnt++. The tick with drain_cnt==DRAIN_LEN-1 moves to IDLE and done<=1 for one cycle. sym_ready=0 throughout; start and stop ignored.
- Latency: start sampled at edge k -> first tick edge at k+CLK_DIV -> first samp_en cycle begins at edge k+CLK_DIV.
- Reset asserted mid-RUN/DRAIN: immediate abort, no done pulse, x_out=0.

Optional Feature:
SYM_PRBS_EN
- Defined:
  - Adds input port prbs_sel (1 bit).
  - With prbs_sel=1 in RUN, symbols come from an internal 7-bit LFSR x^7+x^6+1, reset seed 7'h7F, advanced two steps per symbol; the symbol is {bit after step 1, bit after step 2}.
  - sym_ready held 0 and underrun never set.
  - prbs_sel is sampled only at phase-0 ticks.
- Undefined: no prbs_sel port, no LFSR; symbols only from sym_in.

Test Plan:
- Reset mid-RUN with CLK_DIV=4, SPS=4: assert reset -> same cycle x_out=0, busy=0, samp_en=0; release then start -> normal run, no done pulse from the aborted run.
- start, sym_valid=1, sym_in sequence 00, 01, 11, 10 -> samp_en every 4 clocks; x_out sequence -49152,0,0,0, -16384,0,0,0, 16384,0,0,0, 49152,0,0,0; sym_ready pulses every 16 clocks.
- sym_valid=0 at the second symbol boundary -> x_out=0 for that slot, underrun=1 and stays 1; the next start clears it.
- stop pulsed at phase 1 of a symbol -> the remaining 3 samples are emitted, then exactly 21 zero samples, done=1 for one cycle 84 clocks after the last RUN tick, busy=0 the next cycle.
- start and stop asserted the same cycle in IDLE -> RUN entered, stop_pend=0, run continues; start asserted during RUN/DRAIN -> no effect.
- SYM_PRBS_EN defined, prbs_sel=1 -> sym_ready stays 0; first 4 symbol levels match the reference LFSR model from seed 7'h7F; underrun stays 0 with sym_valid=0.
